// File: rtl/hdmi_tmds_encoder.sv
// HDMI TMDS encoder: NUM_CH parallel channels, two-stage pipeline.
// Stage 1 registers the transition-minimised word q_m plus mode/ctrl/aux.
// Stage 2 selects the output symbol and keeps a per-channel running disparity.
// Build option: define TMDS_TERC4_EN to enable TERC4 data-island coding;
// without it mode 10 encodes as a control period and aux is ignored.
module hdmi_tmds_encoder #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [1:0]            mode,
    input  logic [2*NUM_CH-1:0]   ctrl,
    input  logic [8*NUM_CH-1:0]   data,
    input  logic [4*NUM_CH-1:0]   aux,
    output logic                  out_valid,
    output logic [10*NUM_CH-1:0]  tmds
);

    typedef enum logic [1:0] {
        MODE_CTRL   = 2'b00,
        MODE_VIDEO  = 2'b01,
        MODE_ISLAND = 2'b10,
        MODE_GUARD  = 2'b11
    } mode_e;

    localparam logic [9:0] GUARD_EVEN = 10'b1011001100;
    localparam logic [9:0] GUARD_ODD  = 10'b0100110011;
    localparam logic signed [CNT_W-1:0] TWO  = CNT_W'(2);
    localparam logic signed [CNT_W-1:0] ZERO = '0;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) n = n + 4'(v[i]);
        return n;
    endfunction

    function automatic logic [8:0] tm_encode(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n1;
        logic       use_xnor;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int unsigned i = 1; i < 8; i++)
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

`ifdef TMDS_TERC4_EN
    function automatic logic [9:0] terc4_sym(input logic [3:0] a);
        logic [9:0] s;
        case (a)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000110;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction
`endif

    logic                 v1;
    mode_e                mode_r;
    logic [2*NUM_CH-1:0]  ctrl_r;
    logic [8:0]           qm_r [NUM_CH];

    // Stage 1: capture qualified inputs and the transition-minimised words
    always_ff @(posedge clk) begin
        if (reset) begin
            v1     <= 1'b0;
            mode_r <= MODE_CTRL;
            ctrl_r <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) qm_r[i] <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                mode_r <= mode_e'(mode);
                ctrl_r <= ctrl;
                for (int unsigned i = 0; i < NUM_CH; i++)
                    qm_r[i] <= tm_encode(data[8*i +: 8]);
            end
        end
    end

`ifdef TMDS_TERC4_EN
    logic [4*NUM_CH-1:0] aux_r;

    // Stage 1: capture TERC4 nibbles alongside the other qualified inputs
    always_ff @(posedge clk) begin
        if (reset)         aux_r <= '0;
        else if (in_valid) aux_r <= aux;
    end
`else
    logic unused_aux;
    assign unused_aux = ^aux;
`endif

    // Stage 2: output-valid follows stage-1 valid by one cycle
    always_ff @(posedge clk) begin
        if (reset) out_valid <= 1'b0;
        else       out_valid <= v1;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [9:0]              sym_r, sym_n;
        logic signed [CNT_W-1:0] cnt_r, cnt_n;
        logic signed [CNT_W-1:0] n1s, n0s, diff;
        logic [8:0]              qm;

        // Stage 2 next state: symbol selection and disparity update; idle cycles hold
        always_comb begin
            qm    = qm_r[g];
            n1s   = CNT_W'(ones8(qm[7:0]));
            n0s   = CNT_W'(8) - n1s;
            diff  = n1s - n0s;
            sym_n = sym_r;
            cnt_n = cnt_r;
            if (v1) begin
                case (mode_r)
                    MODE_VIDEO: begin
                        if (cnt_r == ZERO || n1s == n0s) begin
                            sym_n = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                            cnt_n = qm[8] ? (cnt_r + diff) : (cnt_r - diff);
                        end else if ((!cnt_r[CNT_W-1] && n1s > n0s) ||
                                     ( cnt_r[CNT_W-1] && n0s > n1s)) begin
                            sym_n = {1'b1, qm[8], ~qm[7:0]};
                            cnt_n = cnt_r + (qm[8] ? TWO : ZERO) - diff;
                        end else begin
                            sym_n = {1'b0, qm[8], qm[7:0]};
                            cnt_n = cnt_r - (qm[8] ? ZERO : TWO) + diff;
                        end
                    end
                    MODE_GUARD: begin
                        sym_n = (g % 2 == 0) ? GUARD_EVEN : GUARD_ODD;
                        cnt_n = ZERO;
                    end
`ifdef TMDS_TERC4_EN
                    MODE_ISLAND: begin
                        sym_n = terc4_sym(aux_r[4*g +: 4]);
                        cnt_n = ZERO;
                    end
`endif
                    default: begin
                        sym_n = ctrl_sym(ctrl_r[2*g +: 2]);
                        cnt_n = ZERO;
                    end
                endcase
            end
        end

        // Stage 2 registers: output symbol and running disparity
        always_ff @(posedge clk) begin
            if (reset) begin
                sym_r <= '0;
                cnt_r <= ZERO;
            end else begin
                sym_r <= sym_n;
                cnt_r <= cnt_n;
            end
        end

        assign tmds[10*g +: 10] = sym_r;
    end

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Scoreboard bench for hdmi_tmds_encoder: the driver computes each expected
// symbol from a rule-level model and queues it; a monitor on the falling
// edge checks out_valid timing, symbols, and hold-on-idle behaviour.
module tb_hdmi_tmds_encoder;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 5;
    localparam int SW     = 10 * NUM_CH;

    logic                 clk      = 1'b0;
    logic                 reset    = 1'b1;
    logic                 in_valid = 1'b0;
    logic [1:0]           mode     = 2'b00;
    logic [2*NUM_CH-1:0]  ctrl     = '0;
    logic [8*NUM_CH-1:0]  data     = '0;
    logic [4*NUM_CH-1:0]  aux      = '0;
    logic                 out_valid;
    logic [SW-1:0]        tmds;

    hdmi_tmds_encoder #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .mode     (mode),
        .ctrl     (ctrl),
        .data     (data),
        .aux      (aux),
        .out_valid(out_valid),
        .tmds     (tmds)
    );

    always #5 clk = ~clk;

    int slot = 0;
    always @(posedge clk) slot <= slot + 1;

    // ev[k]: out_valid expected at the falling edge of slot k; rz[k]: tmds cleared by reset
    bit ev [0:8191];
    bit rz [0:8191];

    typedef struct {
        logic [SW-1:0] sym;
        int            slot;
    } item_t;
    item_t sb[$];

    int disp [NUM_CH];
    int compared   = 0;
    int mismatched = 0;

    logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011,
                                 10'b0101010100, 10'b1010101011};
    logic [9:0] terc_tab [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    function automatic int wrap(input int x);
        int m, r;
        m = 1 << CNT_W;
        r = x % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    task automatic expect_symbol(input logic [1:0] m, input logic [2*NUM_CH-1:0] ci,
                                 input logic [8*NUM_CH-1:0] di, input logic [4*NUM_CH-1:0] ai,
                                 output logic [SW-1:0] sym);
        logic [7:0] d, qm, mk;
        logic       q8;
        bit         xs;
        int         n, n1, n0, cnt;
        sym = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m == 2'b01) begin
                d  = di[8*c +: 8];
                n  = $countones(d);
                xs = (n > 4) || (n == 4 && d[0] == 1'b0);
                // each q_m bit is the parity of the data prefix, inverted on odd bits for XNOR
                for (int k = 0; k < 8; k++) begin
                    mk    = 8'((1 << (k + 1)) - 1);
                    qm[k] = (^(d & mk)) ^ (xs && (k % 2 == 1));
                end
                q8  = !xs;
                n1  = $countones(qm);
                n0  = 8 - n1;
                cnt = disp[c];
                if (cnt == 0 || n1 == n0) begin
                    sym[10*c +: 10] = {~q8, q8, q8 ? qm : ~qm};
                    cnt += q8 ? (n1 - n0) : (n0 - n1);
                end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
                    sym[10*c +: 10] = {1'b1, q8, ~qm};
                    cnt += 2 * int'(q8) + (n0 - n1);
                end else begin
                    sym[10*c +: 10] = {1'b0, q8, qm};
                    cnt += -2 * int'(!q8) + (n1 - n0);
                end
                disp[c] = wrap(cnt);
            end else begin
                if (m == 2'b11)
                    sym[10*c +: 10] = (c % 2 == 0) ? 10'b1011001100 : 10'b0100110011;
`ifdef TMDS_TERC4_EN
                else if (m == 2'b10)
                    sym[10*c +: 10] = terc_tab[ai[4*c +: 4]];
`endif
                else
                    sym[10*c +: 10] = ctrl_tab[ci[2*c +: 2]];
                disp[c] = 0;
            end
        end
    endtask

    task automatic drive(input bit rst, input bit v, input logic [1:0] m,
                         input logic [2*NUM_CH-1:0] ci, input logic [8*NUM_CH-1:0] di,
                         input logic [4*NUM_CH-1:0] ai);
        logic [SW-1:0] sym;
        item_t         it;
        int            s;
        @(posedge clk);
        #1;
        s        = slot;
        reset    = rst;
        in_valid = v;
        mode     = m;
        ctrl     = ci;
        data     = di;
        aux      = ai;
        if (rst) begin
            // anything issued in the previous slot is still in the pipe and is lost
            ev[s+1] = 1'b0;
            ev[s+2] = 1'b0;
            rz[s+1] = 1'b1;
            while (sb.size() > 0 && sb[sb.size()-1].slot >= s - 1) void'(sb.pop_back());
            for (int c = 0; c < NUM_CH; c++) disp[c] = 0;
        end else if (v) begin
            expect_symbol(m, ci, di, ai, sym);
            it.sym  = sym;
            it.slot = s;
            sb.push_back(it);
            ev[s+2] = 1'b1;
        end
    endtask

    task automatic rand_fields(output logic [2*NUM_CH-1:0] ci, output logic [8*NUM_CH-1:0] di,
                               output logic [4*NUM_CH-1:0] ai);
        for (int c = 0; c < NUM_CH; c++) begin
            ci[2*c +: 2] = 2'($urandom_range(0, 3));
            di[8*c +: 8] = 8'($urandom_range(0, 255));
            ai[4*c +: 4] = 4'($urandom_range(0, 15));
        end
    endtask

    // Monitor: check valid timing every cycle, pop expected symbols, check hold when idle
    initial begin : monitor
        logic [SW-1:0] last;
        item_t         it;
        int            k;
        last = '0;
        forever begin
            @(negedge clk);
            k = slot;
            if (rz[k]) last = '0;
            compared++;
            if (out_valid !== ev[k]) begin
                mismatched++;
                $display("FAIL out_valid slot %0d: got %b want %b", k, out_valid, ev[k]);
            end
            compared++;
            if (ev[k]) begin
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL scoreboard_empty slot %0d: got tmds %h want a queued symbol", k, tmds);
                end else begin
                    it = sb.pop_front();
                    if (tmds !== it.sym) begin
                        mismatched++;
                        $display("FAIL tmds slot %0d (issued %0d): got %b want %b", k, it.slot, tmds, it.sym);
                    end
                    last = it.sym;
                end
            end else if (tmds !== last) begin
                mismatched++;
                $display("FAIL tmds_hold slot %0d: got %b want %b", k, tmds, last);
            end
        end
    end

    initial begin : driver
        logic [2*NUM_CH-1:0] ci;
        logic [8*NUM_CH-1:0] di;
        logic [4*NUM_CH-1:0] ai;
        logic [1:0]          m;
        bit                  v;
        int                  rst_left;
        rz[1] = 1'b1;
        for (int c = 0; c < NUM_CH; c++) disp[c] = 0;

        // reset, then idle with reset released
        repeat (3) drive(1, 0, 2'b00, '0, '0, '0);
        repeat (3) drive(0, 0, 2'b00, '0, '0, '0);

        // video 0x00 twice: 0100000000 then 1111111111
        repeat (2) drive(0, 1, 2'b01, '0, '0, '0);

        // control codes 00,01,10,11
        for (int i = 0; i < 4; i++) drive(0, 1, 2'b00, {NUM_CH{2'(i)}}, '0, '0);

        // guard band, then video restarting from zero disparity
        drive(0, 1, 2'b11, '0, '0, '0);
        drive(0, 1, 2'b01, '0, '0, '0);
        drive(0, 1, 2'b01, '0, '0, '0);

        // data island with aux 0000 and ctrl 00
        drive(0, 1, 2'b10, '0, '0, '0);
        drive(0, 0, 2'b00, '0, '0, '0);

        // randomised traffic with occasional reset pulses
        rst_left = 0;
        for (int i = 0; i < 600; i++) begin
            rand_fields(ci, di, ai);
            m = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
            v = ($urandom_range(0, 3) != 0);
            if (rst_left == 0 && $urandom_range(0, 79) == 0) rst_left = $urandom_range(1, 2);
            if (rst_left > 0) begin
                rst_left--;
                drive(1, v, m, ci, di, ai);
            end else begin
                drive(0, v, m, ci, di, ai);
            end
        end

        // video with in_valid toggling every cycle and a reset mid-stream
        for (int i = 0; i < 40; i++) begin
            rand_fields(ci, di, ai);
            drive((i == 20 || i == 21), (i % 2 == 0), 2'b01, ci, di, ai);
        end

        repeat (5) drive(0, 0, 2'b00, '0, '0, '0);
        @(negedge clk);
        #1;
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d symbols left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
